// File: rtl/morse_key_decoder.sv
// morse_key_decoder: turns a debounced straight-key level into Morse symbols,
// decoded ASCII characters and word-space events. Press and gap lengths are
// classified against thresholds that are sampled live on every cycle.
module morse_key_decoder #(
  parameter int MAX_SYM = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               key_in,
  input  logic [31:0]        long_key_cycles,
  input  logic [31:0]        timeout_cycles,
  input  logic [31:0]        space_cycles,
  output logic               char_valid,
  output logic [7:0]         char_ascii,
  output logic [MAX_SYM-1:0] sym_pattern,
  output logic [2:0]         sym_len,
  output logic               overflow,
  output logic               word_space,
  output logic               busy
);

  // Symbol capacity as a length value; the length register is 3 bits wide.
  localparam logic [2:0] MAX_LEN = 3'(MAX_SYM);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_GAP,
    S_WORDWAIT
  } state_t;

  state_t             state_q, state_d;
  logic               key_prev_q;
  logic [31:0]        press_cnt_q, press_cnt_d;
  logic [31:0]        gap_cnt_q, gap_cnt_d;
  logic [MAX_SYM-1:0] pattern_q, pattern_d;
  logic [2:0]         len_q, len_d;
  logic               ovf_q, ovf_d;
  logic               char_valid_q, char_valid_d;
  logic [7:0]         char_ascii_q, char_ascii_d;
  logic [MAX_SYM-1:0] sym_pattern_q, sym_pattern_d;
  logic [2:0]         sym_len_q, sym_len_d;
  logic               overflow_q, overflow_d;
  logic               word_space_q, word_space_d;

  logic               rise;
  logic [31:0]        press_inc;
  logic [31:0]        gap_inc;
  logic [31:0]        timeout_thr;
  logic [32:0]        timeout_p1;
  logic [32:0]        space_thr;
  logic               sym_dah;
  logic [5:0]         pat6;
  logic [7:0]         decoded;

  assign rise = key_in & ~key_prev_q;

  // Saturating increments so a stuck key or an idle line never wraps.
  assign press_inc = (press_cnt_q == 32'hFFFF_FFFF) ? press_cnt_q : press_cnt_q + 32'd1;
  assign gap_inc   = (gap_cnt_q == 32'hFFFF_FFFF) ? gap_cnt_q : gap_cnt_q + 32'd1;

  // Effective thresholds: a character needs at least one gap cycle, and a word
  // gap always lands strictly after the character gap.
  assign timeout_thr = (timeout_cycles == 32'd0) ? 32'd1 : timeout_cycles;
  assign timeout_p1  = {1'b0, timeout_cycles} + 33'd1;
  assign space_thr   = ({1'b0, space_cycles} > timeout_p1) ? {1'b0, space_cycles} : timeout_p1;

  assign sym_dah = (press_cnt_q >= long_key_cycles);

  // Six-bit view of the pattern for the table lookup; missing bits read as 0.
  for (genvar gi = 0; gi < 6; gi++) begin : g_pat6
    if (gi < MAX_SYM) begin : g_bit
      assign pat6[gi] = pattern_q[gi];
    end else begin : g_zero
      assign pat6[gi] = 1'b0;
    end
  end

  // ITU Morse table keyed on {length, right-aligned pattern}; dit=0, dah=1.
  function automatic logic [7:0] itu_decode(input logic [2:0] len, input logic [5:0] pat);
    logic [7:0] ch;
    ch = 8'h3F;
    case ({len, pat})
      {3'd2, 6'b000001}: ch = "A";
      {3'd4, 6'b001000}: ch = "B";
      {3'd4, 6'b001010}: ch = "C";
      {3'd3, 6'b000100}: ch = "D";
      {3'd1, 6'b000000}: ch = "E";
      {3'd4, 6'b000010}: ch = "F";
      {3'd3, 6'b000110}: ch = "G";
      {3'd4, 6'b000000}: ch = "H";
      {3'd2, 6'b000000}: ch = "I";
      {3'd4, 6'b000111}: ch = "J";
      {3'd3, 6'b000101}: ch = "K";
      {3'd4, 6'b000100}: ch = "L";
      {3'd2, 6'b000011}: ch = "M";
      {3'd2, 6'b000010}: ch = "N";
      {3'd3, 6'b000111}: ch = "O";
      {3'd4, 6'b000110}: ch = "P";
      {3'd4, 6'b001101}: ch = "Q";
      {3'd3, 6'b000010}: ch = "R";
      {3'd3, 6'b000000}: ch = "S";
      {3'd1, 6'b000001}: ch = "T";
      {3'd3, 6'b000001}: ch = "U";
      {3'd4, 6'b000001}: ch = "V";
      {3'd3, 6'b000011}: ch = "W";
      {3'd4, 6'b001001}: ch = "X";
      {3'd4, 6'b001011}: ch = "Y";
      {3'd4, 6'b001100}: ch = "Z";
      {3'd5, 6'b011111}: ch = "0";
      {3'd5, 6'b001111}: ch = "1";
      {3'd5, 6'b000111}: ch = "2";
      {3'd5, 6'b000011}: ch = "3";
      {3'd5, 6'b000001}: ch = "4";
      {3'd5, 6'b000000}: ch = "5";
      {3'd5, 6'b010000}: ch = "6";
      {3'd5, 6'b011000}: ch = "7";
      {3'd5, 6'b011100}: ch = "8";
      {3'd5, 6'b011110}: ch = "9";
      default:           ch = 8'h3F;
    endcase
    return ch;
  endfunction

  assign decoded = ovf_q ? 8'h3F : itu_decode(len_q, pat6);

  // State and datapath registers. key_prev resets high so a key already held
  // when reset releases is not mistaken for a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      key_prev_q    <= 1'b1;
      press_cnt_q   <= '0;
      gap_cnt_q     <= '0;
      pattern_q     <= '0;
      len_q         <= '0;
      ovf_q         <= 1'b0;
      char_valid_q  <= 1'b0;
      char_ascii_q  <= '0;
      sym_pattern_q <= '0;
      sym_len_q     <= '0;
      overflow_q    <= 1'b0;
      word_space_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_prev_q    <= key_in;
      press_cnt_q   <= press_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      pattern_q     <= pattern_d;
      len_q         <= len_d;
      ovf_q         <= ovf_d;
      char_valid_q  <= char_valid_d;
      char_ascii_q  <= char_ascii_d;
      sym_pattern_q <= sym_pattern_d;
      sym_len_q     <= sym_len_d;
      overflow_q    <= overflow_d;
      word_space_q  <= word_space_d;
    end
  end

  // Next-state logic: classify presses, count gaps, emit characters and word
  // spaces. A rise always beats a gap threshold reached in the same cycle.
  always_comb begin
    state_d       = state_q;
    press_cnt_d   = press_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    pattern_d     = pattern_q;
    len_d         = len_q;
    ovf_d         = ovf_q;
    char_valid_d  = 1'b0;
    char_ascii_d  = char_ascii_q;
    sym_pattern_d = sym_pattern_q;
    sym_len_d     = sym_len_q;
    overflow_d    = overflow_q;
    word_space_d  = 1'b0;

    if (!enable) begin
      state_d       = S_IDLE;
      press_cnt_d   = '0;
      gap_cnt_d     = '0;
      pattern_d     = '0;
      len_d         = '0;
      ovf_d         = 1'b0;
      char_ascii_d  = '0;
      sym_pattern_d = '0;
      sym_len_d     = '0;
      overflow_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            state_d     = S_PRESS;
            press_cnt_d = 32'd1;
          end
        end
        S_PRESS: begin
          if (key_in) begin
            press_cnt_d = press_inc;
          end else begin
            if (len_q < MAX_LEN) begin
              pattern_d = {pattern_q[MAX_SYM-2:0], sym_dah};
              len_d     = len_q + 3'd1;
            end else begin
              ovf_d = 1'b1;
            end
            gap_cnt_d = 32'd1;
            state_d   = S_GAP;
          end
        end
        S_GAP: begin
          if (rise) begin
            state_d     = S_PRESS;
            press_cnt_d = 32'd1;
          end else begin
            gap_cnt_d = gap_inc;
            if (gap_inc >= timeout_thr) begin
              char_valid_d  = 1'b1;
              char_ascii_d  = decoded;
              sym_pattern_d = pattern_q;
              sym_len_d     = len_q;
              overflow_d    = ovf_q;
              pattern_d     = '0;
              len_d         = '0;
              ovf_d         = 1'b0;
              state_d       = S_WORDWAIT;
            end
          end
        end
        S_WORDWAIT: begin
          if (rise) begin
            state_d     = S_PRESS;
            press_cnt_d = 32'd1;
          end else begin
            gap_cnt_d = gap_inc;
            if ({1'b0, gap_inc} >= space_thr) begin
              word_space_d = 1'b1;
              gap_cnt_d    = '0;
              state_d      = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign char_valid  = char_valid_q;
  assign char_ascii  = char_ascii_q;
  assign sym_pattern = sym_pattern_q;
  assign sym_len     = sym_len_q;
  assign overflow    = overflow_q;
  assign word_space  = word_space_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed bench for morse_key_decoder: keys hand-timed presses and gaps and
// compares captured events against hand-computed characters and latencies.
module tb_morse_key_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        key_in = 1'b0;
  logic [31:0] long_key_cycles = 32'd10;
  logic [31:0] timeout_cycles = 32'd30;
  logic [31:0] space_cycles = 32'd60;
  logic        char_valid;
  logic [7:0]  char_ascii;
  logic [5:0]  sym_pattern;
  logic [2:0]  sym_len;
  logic        overflow;
  logic        word_space;
  logic        busy;

  morse_key_decoder #(.MAX_SYM(6)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .key_in          (key_in),
    .long_key_cycles (long_key_cycles),
    .timeout_cycles  (timeout_cycles),
    .space_cycles    (space_cycles),
    .char_valid      (char_valid),
    .char_ascii      (char_ascii),
    .sym_pattern     (sym_pattern),
    .sym_len         (sym_len),
    .overflow        (overflow),
    .word_space      (word_space),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Count of rising edges so far; read on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge away from the active edge.
  int         cv_cnt = 0;
  int         ws_cnt = 0;
  int         both_cnt = 0;
  int         cv_cyc = 0;
  int         ws_cyc = 0;
  logic [7:0] cv_ascii = '0;
  logic [5:0] cv_pat = '0;
  logic [2:0] cv_len = '0;
  logic       cv_ovf = 1'b0;
  always @(negedge clk) begin
    if (char_valid) begin
      cv_cnt   <= cv_cnt + 1;
      cv_cyc   <= cyc;
      cv_ascii <= char_ascii;
      cv_pat   <= sym_pattern;
      cv_len   <= sym_len;
      cv_ovf   <= overflow;
    end
    if (word_space) begin
      ws_cnt <= ws_cnt + 1;
      ws_cyc <= cyc;
    end
    if (char_valid && word_space) both_cnt <= both_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Hold the key at a level for n sampling edges, starting at a falling edge.
  task automatic drive(input logic lvl, input int n);
    key_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_clear();
    key_in = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [31:0] all_outs();
    return {11'd0, char_valid, char_ascii, sym_pattern, sym_len, overflow, word_space, busy};
  endfunction

  int cv0, ws0, t_low;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_outs", all_outs(), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("post_rst_busy", {31'd0, busy}, 32'd0);

    // E: press 5, low 35
    idle_clear();
    cv0 = cv_cnt; ws0 = ws_cnt;
    drive(1'b1, 5);
    t_low = cyc;
    drive(1'b0, 35);
    $display("txn E: chars=%0d ascii=0x%0h len=%0d pat=%b", cv_cnt - cv0, cv_ascii, cv_len, cv_pat);
    check_eq("e_count", cv_cnt - cv0, 1);
    check_eq("e_ascii", {24'd0, cv_ascii}, 32'h45);
    check_eq("e_len", {29'd0, cv_len}, 1);
    check_eq("e_pat", {26'd0, cv_pat}, 0);
    check_eq("e_ovf", {31'd0, cv_ovf}, 0);
    check_eq("e_latency", cv_cyc - t_low, 30);
    check_eq("e_no_ws", ws_cnt - ws0, 0);
    check_eq("e_hold", {24'd0, char_ascii}, 32'h45);
    check_eq("e_busy", {31'd0, busy}, 1);

    // A: press 5, low 8, press 15, low 40
    idle_clear();
    cv0 = cv_cnt;
    drive(1'b1, 5); drive(1'b0, 8); drive(1'b1, 15); drive(1'b0, 40);
    $display("txn A: chars=%0d ascii=0x%0h len=%0d pat=%b", cv_cnt - cv0, cv_ascii, cv_len, cv_pat);
    check_eq("a_count", cv_cnt - cv0, 1);
    check_eq("a_ascii", {24'd0, cv_ascii}, 32'h41);
    check_eq("a_len", {29'd0, cv_len}, 2);
    check_eq("a_pat", {26'd0, cv_pat}, 32'b01);

    // T: press exactly the long threshold
    idle_clear();
    cv0 = cv_cnt;
    drive(1'b1, 10); drive(1'b0, 40);
    $display("txn T: chars=%0d ascii=0x%0h len=%0d pat=%b", cv_cnt - cv0, cv_ascii, cv_len, cv_pat);
    check_eq("t_count", cv_cnt - cv0, 1);
    check_eq("t_ascii", {24'd0, cv_ascii}, 32'h54);
    check_eq("t_pat", {26'd0, cv_pat}, 32'b1);

    // One cycle short of the long threshold is a dit
    idle_clear();
    cv0 = cv_cnt;
    drive(1'b1, 9); drive(1'b0, 40);
    $display("txn E9: chars=%0d ascii=0x%0h len=%0d pat=%b", cv_cnt - cv0, cv_ascii, cv_len, cv_pat);
    check_eq("e9_count", cv_cnt - cv0, 1);
    check_eq("e9_ascii", {24'd0, cv_ascii}, 32'h45);

    // Word space: press 5, low 70
    idle_clear();
    cv0 = cv_cnt; ws0 = ws_cnt;
    drive(1'b1, 5);
    t_low = cyc;
    drive(1'b0, 70);
    $display("txn WS: chars=%0d ascii=0x%0h spaces=%0d", cv_cnt - cv0, cv_ascii, ws_cnt - ws0);
    check_eq("ws_char", {24'd0, cv_ascii}, 32'h45);
    check_eq("ws_cv_latency", cv_cyc - t_low, 30);
    check_eq("ws_count", ws_cnt - ws0, 1);
    check_eq("ws_latency", ws_cyc - t_low, 60);
    check_eq("ws_busy", {31'd0, busy}, 0);

    // Overflow: seven dits
    idle_clear();
    cv0 = cv_cnt;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 5); drive(1'b0, 8);
    end
    drive(1'b0, 40);
    $display("txn OVF: chars=%0d ascii=0x%0h len=%0d ovf=%0d", cv_cnt - cv0, cv_ascii, cv_len, cv_ovf);
    check_eq("ovf_count", cv_cnt - cv0, 1);
    check_eq("ovf_ascii", {24'd0, cv_ascii}, 32'h3F);
    check_eq("ovf_flag", {31'd0, cv_ovf}, 1);
    check_eq("ovf_len", {29'd0, sym_len}, 6);
    check_eq("ovf_pat", {26'd0, cv_pat}, 0);

    // Reset mid-gap with a character already held on the outputs
    cv0 = cv_cnt; ws0 = ws_cnt;
    drive(1'b1, 5); drive(1'b0, 8);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 100);
    $display("txn RST: chars=%0d spaces=%0d", cv_cnt - cv0, ws_cnt - ws0);
    check_eq("rst_no_char", cv_cnt - cv0, 0);
    check_eq("rst_no_ws", ws_cnt - ws0, 0);
    check_eq("rst_outs_after", all_outs(), 32'd0);

    // Enable drop mid-gap right after an emitted character
    cv0 = cv_cnt; ws0 = ws_cnt;
    drive(1'b1, 5); drive(1'b0, 40);
    drive(1'b1, 5); drive(1'b0, 8);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    drive(1'b0, 100);
    $display("txn EN: chars=%0d spaces=%0d", cv_cnt - cv0, ws_cnt - ws0);
    check_eq("en_one_char", cv_cnt - cv0, 1);
    check_eq("en_no_ws", ws_cnt - ws0, 0);
    check_eq("en_outs_after", all_outs(), 32'd0);

    // Key held across an enable drop: the held level is not a new press
    cv0 = cv_cnt;
    drive(1'b1, 5);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    drive(1'b1, 5);
    check_eq("held_not_busy", {31'd0, busy}, 0);
    drive(1'b0, 100);
    $display("txn HELD: chars=%0d", cv_cnt - cv0);
    check_eq("held_no_char", cv_cnt - cv0, 0);

    check_eq("ws_cv_overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
